// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding a start/data/parity/stop serialiser
// with a runtime-selectable frame format and a per-bit reloaded baud counter.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no frame in progress, waiting for en and a queued byte
// S_START  | start bit (txd low)
// S_DATA   | data bits, LSB first, latched count of 5..8
// S_PARITY | parity bit over the transmitted data bits only
// S_STOP   | one or two stop bits (txd high); tx_done on the last one
module uart_tx_buffered #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [1:0]                    cfg_dbits,
    input  logic [1:0]                    cfg_par,
    input  logic                          cfg_stop,
    output logic                          txd,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_en_q, par_en_d;
    logic             par_bit_q, par_bit_d;
    logic             stop2_q, stop2_d;
    logic             txd_q, txd_d;

    logic       wr_accept;
    logic       pop;
    logic       can_start;
    logic       bit_end;
    logic [7:0] head;
    logic [3:0] nbits;
    logic [7:0] masked;

    assign wr_ready   = (count_q < DEPTH_C);
    assign wr_accept  = wr_valid && wr_ready;
    assign can_start  = en && (count_q != '0);
    assign bit_end    = (baud_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign nbits      = 4'd5 + {2'b00, cfg_dbits};
    assign masked     = head & (8'hFF >> (4'd8 - nbits));

    assign txd        = txd_q;
    assign busy       = (state_q != S_IDLE);
    assign tx_done    = (state_q == S_STOP) && bit_end && !stop2_q;
    assign fifo_count = count_q;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        pop       = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? cfg_div : baud_q - DIV_W'(1);
        end

        case (state_q)
            S_IDLE: pop = can_start;
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d  = shift_q >> 1;
                    bitcnt_d = bitcnt_q - 4'd1;
                    if (bitcnt_q == 4'd1) state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop2_q) begin
                        stop2_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        pop     = can_start;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame format is captured here so mid-frame config writes only affect later frames.
        if (pop) begin
            state_d   = S_START;
            baud_d    = cfg_div;
            shift_d   = head;
            bitcnt_d  = nbits;
            par_en_d  = (cfg_par == 2'b01) || (cfg_par == 2'b10);
            par_bit_d = (cfg_par == 2'b01) ? ~^masked : ^masked;
            stop2_d   = cfg_stop;
        end
    end

    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_q[0];
            S_PARITY: txd_d = par_bit_q;
            default:  txd_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_accept);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(wr_accept) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            txd_q     <= txd_d;
        end
    end

endmodule
